// File: rtl/msgpu_bus_rx.sv
// msgpu_bus_rx: receiver for the MCU parallel bus feeding the msgpu core.
// Synchronises the asynchronous bus strobe, tags each beat as command or data,
// assembles data beats into WORD_BEATS-wide words, and buffers entries in a
// first-word-fall-through FIFO with a valid/ready output.
// Optional build macro MSGPU_BUS_RX_STATS_EN adds saturating 16-bit counters
// stat_commands, stat_words and stat_dropped.

module msgpu_bus_rx #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned WORD_BEATS  = 2,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                mcu_bus_clock,
  input  logic [BUS_WIDTH-1:0]                mcu_bus,
  input  logic                                mcu_bus_command_data,
  output logic [BUS_WIDTH*WORD_BEATS-1:0]     out_data,
  output logic                                out_is_command,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                overflow,
  input  logic                                clear_overflow
`ifdef MSGPU_BUS_RX_STATS_EN
  ,
  output logic [15:0]                         stat_commands,
  output logic [15:0]                         stat_words,
  output logic [15:0]                         stat_dropped
`endif
);

  localparam int unsigned WordW = BUS_WIDTH * WORD_BEATS;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned Last  = SYNC_STAGES - 1;

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]                strobe_sync_q, strobe_sync_d;
  logic [SYNC_STAGES-1:0]                flag_sync_q, flag_sync_d;
  logic [SYNC_STAGES-1:0][BUS_WIDTH-1:0] bus_sync_q, bus_sync_d;
  // Marks chain stages that hold a sample taken after reset release.
  logic [SYNC_STAGES-1:0]                vld_sync_q, vld_sync_d;
  logic                                  prev_q, prev_d;

  logic                 strobe_last;
  logic                 flag_last;
  logic [BUS_WIDTH-1:0] bus_last;
  logic                 vld_last;
  logic                 beat_edge;

  // Shift every chain by one stage per clock.
  always_comb begin
    strobe_sync_d = {strobe_sync_q[SYNC_STAGES-2:0], mcu_bus_clock};
    flag_sync_d   = {flag_sync_q[SYNC_STAGES-2:0], mcu_bus_command_data};
    bus_sync_d    = {bus_sync_q[SYNC_STAGES-2:0], mcu_bus};
    vld_sync_d    = {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
    strobe_last   = strobe_sync_q[Last];
    flag_last     = flag_sync_q[Last];
    bus_last      = bus_sync_q[Last];
    vld_last      = vld_sync_q[Last];
    // Previous value holds 1 until the chain carries real post-reset samples,
    // so a strobe already high at reset release never looks like a rising edge.
    prev_d        = vld_last ? strobe_last : 1'b1;
    beat_edge     = vld_last && strobe_last && !prev_q;
  end

  // ---------------------------------------------------------------------------
  // Beat tagging and word assembly
  // ---------------------------------------------------------------------------
  logic [2:0]       cnt_q, cnt_d;
  logic [WordW-1:0] word_q, word_d;
  logic [WordW-1:0] word_beat;
  logic             push_q, push_d;
  logic [WordW-1:0] push_data_q, push_data_d;
  logic             push_cmd_q, push_cmd_d;

  // Decide at the edge cycle what is pushed one cycle later.
  always_comb begin
    cnt_d       = cnt_q;
    word_d      = word_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    push_cmd_d  = push_cmd_q;
    word_beat   = word_q;
    for (int b = 0; b < int'(WORD_BEATS); b++) begin
      if (cnt_q == b[2:0]) begin
        word_beat[b*BUS_WIDTH +: BUS_WIDTH] = bus_last;
      end
    end
    if (beat_edge) begin
      if (flag_last) begin
        // Command beat drops any partially assembled word.
        cnt_d                        = 3'd0;
        word_d                       = '0;
        push_d                       = 1'b1;
        push_data_d                  = '0;
        push_data_d[BUS_WIDTH-1:0]   = bus_last;
        push_cmd_d                   = 1'b1;
      end else if (cnt_q == 3'(WORD_BEATS - 1)) begin
        cnt_d       = 3'd0;
        word_d      = '0;
        push_d      = 1'b1;
        push_data_d = word_beat;
        push_cmd_d  = 1'b0;
      end else begin
        cnt_d  = cnt_q + 3'd1;
        word_d = word_beat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [WordW:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic [WordW:0]   head;

  // Pointer, level and overflow next-state.
  always_comb begin
    fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
    fifo_empty = (level_q == '0);
    pop        = !fifo_empty && out_ready;
    // A pop frees the slot for a same-cycle push even when full.
    push_ok    = push_q && (!fifo_full || pop);
    drop       = push_q && fifo_full && !pop;
    wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push_ok) begin
      level_d = level_q - LvlW'(1);
    end
    overflow_d = overflow_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Head of FIFO is presented directly; payload is masked while empty.
  always_comb begin
    head           = mem_q[rd_ptr_q];
    out_valid      = !fifo_empty;
    out_data       = out_valid ? head[WordW-1:0] : '0;
    out_is_command = out_valid && head[WordW];
    fifo_level     = level_q;
    overflow       = overflow_q;
  end

  // FIFO storage; contents need no reset because the output is masked when empty.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {push_cmd_q, push_data_q};
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_sync_q <= '0;
      flag_sync_q   <= '0;
      bus_sync_q    <= '0;
      vld_sync_q    <= '0;
      prev_q        <= 1'b1;
      cnt_q         <= 3'd0;
      word_q        <= '0;
      push_q        <= 1'b0;
      push_data_q   <= '0;
      push_cmd_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      strobe_sync_q <= strobe_sync_d;
      flag_sync_q   <= flag_sync_d;
      bus_sync_q    <= bus_sync_d;
      vld_sync_q    <= vld_sync_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      push_q        <= push_d;
      push_data_q   <= push_data_d;
      push_cmd_q    <= push_cmd_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef MSGPU_BUS_RX_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [15:0] stat_cmd_q, stat_cmd_d;
  logic [15:0] stat_word_q, stat_word_d;
  logic [15:0] stat_drop_q, stat_drop_d;
  logic        discard;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Saturating event counters.
  always_comb begin
    discard     = beat_edge && flag_last && (cnt_q != 3'd0);
    stat_cmd_d  = sat_add(stat_cmd_q, {1'b0, push_ok && push_cmd_q});
    stat_word_d = sat_add(stat_word_q, {1'b0, push_ok && !push_cmd_q});
    stat_drop_d = sat_add(stat_drop_q, {1'b0, drop} + {1'b0, discard});
    stat_commands = stat_cmd_q;
    stat_words    = stat_word_q;
    stat_dropped  = stat_drop_q;
  end

  // Counter state.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_cmd_q  <= '0;
      stat_word_q <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_cmd_q  <= stat_cmd_d;
      stat_word_q <= stat_word_d;
      stat_drop_q <= stat_drop_d;
    end
  end
`endif

endmodule

// File: doc/msgpu_bus_rx.md
Name: msgpu_bus_rx

Overview:
Parametrised receiver for the MCU parallel bus that feeds the msgpu core. It synchronises the asynchronous bus strobe into the system clock domain and tags each beat as command or data. Data beats are assembled into multi-beat words, and entries are buffered in a FIFO with a valid/ready output. It replaces the fixed 8-bit byte-at-a-time bus front end and sits between the board pins and the command decoder.

Parameters:
BUS_WIDTH, 8, width of mcu_bus in bits (4..32)
WORD_BEATS, 2, data beats per assembled data word (1..4)
FIFO_DEPTH, 16, FIFO entries; power of two, >=2
SYNC_STAGES, 2, synchroniser flops on strobe/bus/flag (2..4)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
mcu_bus_clock  input  1  asynchronous bus strobe; beat captured on its rising edge
mcu_bus  input  BUS_WIDTH  bus data
mcu_bus_command_data  input  1  1 = command beat, 0 = data beat
out_data  output  BUS_WIDTH*WORD_BEATS  FIFO head payload
out_is_command  output  1  FIFO head is a command entry
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head when out_valid && out_ready
fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count
overflow  output  1  sticky; an entry was dropped on a full FIFO
clear_overflow  input  1  clears overflow

Behaviour:
- Reset state: all outputs 0, sync chains 0, beat counter 0, partial word cleared, FIFO empty.
- Synchronisation: strobe, bus and flag each pass through SYNC_STAGES flops. Edge cycle E = last strobe stage 1 while its previous value was 0. Beat payload and flag are taken from the last synchronised stage at E.
- Bus timing: the MCU holds bus and flag stable from SYNC_STAGES+1 clocks before the strobe rises until SYNC_STAGES+1 clocks after. Strobe high and low phases are each >= SYNC_STAGES+1 clocks.
- Command beat:
  - Discards any partial data word; beat counter returns to 0.
  - Pushes one entry at E+1: payload zero-extended into out_data[BUS_WIDTH-1:0], is_command=1.
- Data beat:
  - Stored at bits [cnt*BUS_WIDTH +: BUS_WIDTH]; first beat is least significant.
  - cnt increments. When cnt reaches WORD_BEATS, pushes the word at E+1 with is_command=0 and wraps cnt to 0.
  - WORD_BEATS=1 pushes every data beat.
- FIFO:
  - Registered, first-word-fall-through. out_valid rises at E+2 when the FIFO was empty.
  - Pop when out_valid && out_ready.
  - Pop on empty is ignored.
  - Push on full with no simultaneous pop: entry dropped, overflow set the next cycle, level unchanged.
  - Push and pop in the same cycle when full: both accepted, no overflow.
  - Push and pop in the same cycle when empty: push only (head not yet valid).
  - Pointers wrap modulo FIFO_DEPTH. fifo_level 0..FIFO_DEPTH.
- Overflow flag: clear_overflow has priority over a same-cycle overflow set, so the flag ends 0.
- Reset mid-word or mid-strobe:
  - Partial word and FIFO contents are lost.
  - Strobe already high at reset release produces no edge until it falls and rises again (sync chain resets to 0, then edge is detected as 0->1 only after the previous-value flop tracks 1).
  - To guarantee this, the previous-value flop resets to 1.

Optional Feature:
MSGPU_BUS_RX_STATS_EN:
- Defined: adds three outputs, each 16 bits, saturating at 0xFFFF and cleared by reset:
  - stat_commands: counts command entries pushed.
  - stat_words: counts data words pushed.
  - stat_dropped: counts dropped entries plus discarded partial words.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Defaults; data beats 0x34, 0x12 -> one entry out_data=0x1234, is_command=0; out_valid rises exactly 2 cycles after the second edge-detect cycle.
- Data beat 0xAA, then command beat 0x5C -> single entry out_data=0x005C, is_command=1. Next data beats 0x01, 0x02 -> 0x0201.
- out_ready=0; send 17 commands -> fifo_level=16, overflow=1. Pulse clear_overflow -> overflow=0. Drain -> commands 0..15 in order.
- FIFO full, out_ready=1, new push arriving in the same cycle as a pop -> overflow stays 0, level stays 16.
- BUS_WIDTH=4, WORD_BEATS=4; beats 0xD, 0xC, 0xB, 0xA -> out_data=0xABCD. Assert reset after 2 of 4 beats, then send 4 beats 0x1..0x4 -> 0x4321.
- Strobe held high across reset release -> no entry. Next full low/high cycle with bus=0x77, command -> one entry 0x77. With MSGPU_BUS_RX_STATS_EN defined, stat_commands=1.
